// File: rtl/hazard_forward_unit_if.sv
// Bundles the pipeline-side signals seen by the hazard/forwarding unit.
// The master side is the pipeline, which drives the stage fields and
// consumes the stall, flush and select outputs. The slave side is the
// unit itself.
interface hazard_forward_unit_if #(
    parameter int REG_ADDR_W = 2,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  id_valid;
    logic                  id_halt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  ex_redirect;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  halted;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid, id_halt,
        output ex_rd, ex_reg_write, ex_mem_read,
        output mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_redirect,
        input  fwd_a, fwd_b, pc_stall, ifid_stall, ifid_flush, idex_bubble,
        input  halted, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_valid, id_halt,
        input  ex_rd, ex_reg_write, ex_mem_read,
        input  mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_redirect,
        output fwd_a, fwd_b, pc_stall, ifid_stall, ifid_flush, idex_bubble,
        output halted, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// It sits beside ID and resolves RAW hazards against the EX, MEM and WB
// producers. It also raises load-use stalls, multi-cycle redirect flushes
// and a sticky halt. Operand selects are registered, so they are valid
// during the consumer's EX cycle. Stall and flush cycles are counted by a
// saturating counter.
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int ZERO_REG     = 0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    hazard_forward_unit_if.slave  bus_if
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_MEMWB = 2'd1;
    localparam logic [1:0] SEL_EXMEM = 2'd2;
    localparam logic [1:0] SEL_WB    = 2'd3;

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [1:0]       fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic pc_stall, ifid_stall, ifid_flush, idex_bubble;
    logic load_use;
    logic [1:0] sel_a, sel_b;

    // A source matches a producer when it is read and the producer writes
    // that register. A hardwired zero register never matches, and this is
    // decided from the destination value.
    function automatic logic srcMatch(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  p_we,
        input logic [REG_ADDR_W-1:0] p_rd
    );
        return use_src & p_we & (src == p_rd) &
               !((ZERO_REG != 0) && (p_rd == '0));
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, otherwise the register file.
    function automatic logic [1:0] srcSelect(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (srcMatch(use_src, src, bus_if.ex_reg_write, bus_if.ex_rd))
            sel = SEL_EXMEM;
        else if (srcMatch(use_src, src, bus_if.mem_reg_write, bus_if.mem_rd))
            sel = SEL_MEMWB;
        else if (srcMatch(use_src, src, bus_if.wb_reg_write, bus_if.wb_rd))
            sel = SEL_WB;
        return sel;
    endfunction

    // Load-use hazard detection and per-source forwarding selection for the ID instruction.
    always_comb begin
        load_use = bus_if.id_valid & bus_if.ex_mem_read &
                   (srcMatch(bus_if.id_use_rs1, bus_if.id_rs1, bus_if.ex_reg_write, bus_if.ex_rd) |
                    srcMatch(bus_if.id_use_rs2, bus_if.id_rs2, bus_if.ex_reg_write, bus_if.ex_rd));
        sel_a    = srcSelect(bus_if.id_use_rs1, bus_if.id_rs1);
        sel_b    = srcSelect(bus_if.id_use_rs2, bus_if.id_rs2);
    end

    // Next-state logic and Mealy control outputs. Priority is redirect, then halt, then load-use.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus_if.ex_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_RELOAD;
                    end
                end else if (bus_if.id_halt && bus_if.id_valid) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    state_d    = ST_HALT;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                if (bus_if.ex_redirect) begin
                    idex_bubble = 1'b1;
                    fcnt_d      = FLUSH_RELOAD;
                end else if (fcnt_q <= 3'd1) begin
                    fcnt_d  = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    // FSM state and flush-countdown registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Registered operand selects. A bubble or a halt hands EX a register-file operand.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else if (idex_bubble || (state_q == ST_HALT)) begin
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
        end
    end

    // Saturating count of stall or flush cycles. It is frozen while halted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q != ST_HALT) && (pc_stall || ifid_flush) &&
                     (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus_if.fwd_a       = fwd_a_q;
    assign bus_if.fwd_b       = fwd_b_q;
    assign bus_if.pc_stall    = pc_stall;
    assign bus_if.ifid_stall  = ifid_stall;
    assign bus_if.ifid_flush  = ifid_flush;
    assign bus_if.idex_bubble = idex_bubble;
    assign bus_if.halted      = (state_q == ST_HALT);
    assign bus_if.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit. Directed scenarios come
// first, followed by randomized traffic. A behavioural model tracks the
// flush cycles still owed, the halt flag, the event count and the expected
// operand selects.
module tb_hazard_forward_unit;

    localparam int AW           = 2;
    localparam int FLUSH_CYCLES = 3;
    localparam int ZERO_REG     = 1;
    localparam int CNT_W        = 5;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          use1;
        logic          use2;
        logic          valid;
        logic          halt;
        logic [AW-1:0] exRd;
        logic          exWe;
        logic          exMr;
        logic [AW-1:0] memRd;
        logic          memWe;
        logic [AW-1:0] wbRd;
        logic          wbWe;
        logic          redirect;
        logic          rst;
    } stim_t;

    logic clk;
    logic reset;

    hazard_forward_unit_if #(.REG_ADDR_W(AW), .CNT_W(CNT_W)) hfu ();

    hazard_forward_unit #(
        .REG_ADDR_W  (AW),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .ZERO_REG    (ZERO_REG),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_if (hfu.slave)
    );

    int assertCount;
    int failCount;

    int flushLeft;
    bit haltedM;
    int cntM;
    int fwdAM;
    int fwdBM;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.rs1 = '0; s.rs2 = '0; s.use1 = 0; s.use2 = 0; s.valid = 0; s.halt = 0;
        s.exRd = '0; s.exWe = 0; s.exMr = 0; s.memRd = '0; s.memWe = 0;
        s.wbRd = '0; s.wbWe = 0; s.redirect = 0; s.rst = 0;
        return s;
    endfunction

    // A source depends on a producer when it reads the register being written, except r0.
    function automatic bit hits(input logic useSrc, input logic [AW-1:0] src,
                                input logic we, input logic [AW-1:0] rd);
        return useSrc && we && (src == rd) && !(ZERO_REG != 0 && rd == 0);
    endfunction

    // Scan the producers from youngest to oldest and return the select code of the first hit.
    function automatic int expectedSel(input stim_t s, input logic useSrc, input logic [AW-1:0] src);
        logic [AW-1:0] rdList[3];
        logic          weList[3];
        int            codeList[3];
        rdList[0] = s.exRd;  weList[0] = s.exWe;  codeList[0] = 2;
        rdList[1] = s.memRd; weList[1] = s.memWe; codeList[1] = 1;
        rdList[2] = s.wbRd;  weList[2] = s.wbWe;  codeList[2] = 3;
        for (int i = 0; i < 3; i++)
            if (hits(useSrc, src, weList[i], rdList[i])) return codeList[i];
        return 0;
    endfunction

    // Drive one cycle of inputs, check all outputs against the model, then advance the model.
    task automatic applyStimulus(input stim_t s);
        bit lu, ePc, eIfid, eFlush, eBub;
        @(negedge clk);
        reset             = s.rst;
        hfu.id_rs1        = s.rs1;
        hfu.id_rs2        = s.rs2;
        hfu.id_use_rs1    = s.use1;
        hfu.id_use_rs2    = s.use2;
        hfu.id_valid      = s.valid;
        hfu.id_halt       = s.halt;
        hfu.ex_rd         = s.exRd;
        hfu.ex_reg_write  = s.exWe;
        hfu.ex_mem_read   = s.exMr;
        hfu.mem_rd        = s.memRd;
        hfu.mem_reg_write = s.memWe;
        hfu.wb_rd         = s.wbRd;
        hfu.wb_reg_write  = s.wbWe;
        hfu.ex_redirect   = s.redirect;
        #1;
        lu = s.valid && s.exMr &&
             (hits(s.use1, s.rs1, s.exWe, s.exRd) || hits(s.use2, s.rs2, s.exWe, s.exRd));
        ePc = 0; eIfid = 0; eFlush = 0; eBub = 0;
        if (haltedM) begin
            ePc = 1; eIfid = 1; eBub = 1;
        end else if (flushLeft > 0) begin
            eFlush = 1; eBub = s.redirect;
        end else if (s.redirect) begin
            eFlush = 1; eBub = 1;
        end else if (s.halt && s.valid) begin
            ePc = 1; eIfid = 1;
        end else if (lu) begin
            ePc = 1; eIfid = 1; eBub = 1;
        end
        checkOutput("pc_stall",    32'(hfu.pc_stall),    32'(ePc));
        checkOutput("ifid_stall",  32'(hfu.ifid_stall),  32'(eIfid));
        checkOutput("ifid_flush",  32'(hfu.ifid_flush),  32'(eFlush));
        checkOutput("idex_bubble", 32'(hfu.idex_bubble), 32'(eBub));
        checkOutput("halted",      32'(hfu.halted),      32'(haltedM));
        checkOutput("fwd_a",       32'(hfu.fwd_a),       32'(fwdAM));
        checkOutput("fwd_b",       32'(hfu.fwd_b),       32'(fwdBM));
        checkOutput("stall_cnt",   32'(hfu.stall_cnt),   32'(cntM));
        @(posedge clk);
        if (s.rst) begin
            flushLeft = 0; haltedM = 0; cntM = 0; fwdAM = 0; fwdBM = 0;
        end else begin
            if (eBub) begin
                fwdAM = 0; fwdBM = 0;
            end else begin
                fwdAM = expectedSel(s, s.use1, s.rs1);
                fwdBM = expectedSel(s, s.use2, s.rs2);
            end
            if (!haltedM && (ePc || eFlush) && cntM < CNT_MAX) cntM++;
            if (!haltedM) begin
                if (s.redirect)                flushLeft = FLUSH_CYCLES - 1;
                else if (flushLeft > 0)        flushLeft--;
                else if (s.halt && s.valid)    haltedM = 1;
            end
        end
        #1;
    endtask

    initial begin
        stim_t s;
        assertCount = 0;
        failCount   = 0;

        // Bring the DUT out of an unknown state before the model takes over.
        s = idleStim();
        reset = 1'b1;
        hfu.id_rs1 = '0; hfu.id_rs2 = '0; hfu.id_use_rs1 = 0; hfu.id_use_rs2 = 0;
        hfu.id_valid = 0; hfu.id_halt = 0; hfu.ex_rd = '0; hfu.ex_reg_write = 0;
        hfu.ex_mem_read = 0; hfu.mem_rd = '0; hfu.mem_reg_write = 0; hfu.wb_rd = '0;
        hfu.wb_reg_write = 0; hfu.ex_redirect = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        flushLeft = 0; haltedM = 0; cntM = 0; fwdAM = 0; fwdBM = 0;
        checkOutput("reset_halted",    32'(hfu.halted),    0);
        checkOutput("reset_stall_cnt", 32'(hfu.stall_cnt), 0);
        checkOutput("reset_fwd_a",     32'(hfu.fwd_a),     0);

        // ADD r1 in EX, and ID reads r1 as rs1.
        s = idleStim();
        s.valid = 1; s.use1 = 1; s.rs1 = 1; s.use2 = 1; s.rs2 = 2;
        s.exRd = 1; s.exWe = 1;
        applyStimulus(s);
        checkOutput("t1_fwd_a", 32'(hfu.fwd_a),     2);
        checkOutput("t1_fwd_b", 32'(hfu.fwd_b),     0);
        checkOutput("t1_cnt",   32'(hfu.stall_cnt), 0);

        // LWD r2 in EX, and ID reads r2 as rs2. After one stall cycle the load is in MEM.
        s = idleStim(); s.rst = 1; applyStimulus(s);
        s = idleStim();
        s.valid = 1; s.use2 = 1; s.rs2 = 2; s.exRd = 2; s.exWe = 1; s.exMr = 1;
        applyStimulus(s);
        checkOutput("t2_cnt_stall", 32'(hfu.stall_cnt), 1);
        checkOutput("t2_fwd_b_bub", 32'(hfu.fwd_b),     0);
        s.exRd = 0; s.exWe = 0; s.exMr = 0; s.memRd = 2; s.memWe = 1;
        applyStimulus(s);
        checkOutput("t2_fwd_b_mem", 32'(hfu.fwd_b),     1);
        checkOutput("t2_cnt_after", 32'(hfu.stall_cnt), 1);

        // r3 is written in EX, MEM and WB. Then r0 is covered by the hardwired-zero rule.
        s = idleStim(); s.rst = 1; applyStimulus(s);
        s = idleStim();
        s.valid = 1; s.use1 = 1; s.rs1 = 3; s.use2 = 1; s.rs2 = 3;
        s.exRd = 3; s.exWe = 1; s.memRd = 3; s.memWe = 1; s.wbRd = 3; s.wbWe = 1;
        applyStimulus(s);
        checkOutput("t3_fwd_a", 32'(hfu.fwd_a), 2);
        checkOutput("t3_fwd_b", 32'(hfu.fwd_b), 2);
        s.rs1 = 0; s.rs2 = 0; s.exRd = 0; s.exMr = 1; s.memRd = 0; s.wbRd = 0;
        applyStimulus(s);
        checkOutput("t3_r0_fwd_a", 32'(hfu.fwd_a),     0);
        checkOutput("t3_r0_cnt",   32'(hfu.stall_cnt), 0);

        // A single redirect pulse flushes for three cycles.
        s = idleStim(); s.rst = 1; applyStimulus(s);
        s = idleStim(); s.redirect = 1; applyStimulus(s);
        s = idleStim();
        repeat (4) applyStimulus(s);
        checkOutput("t4_cnt", 32'(hfu.stall_cnt), 3);

        // A halt together with a redirect does not halt. A later halt alone is sticky until reset.
        s = idleStim(); s.rst = 1; applyStimulus(s);
        s = idleStim(); s.valid = 1; s.halt = 1; s.redirect = 1; applyStimulus(s);
        checkOutput("t5_no_halt", 32'(hfu.halted), 0);
        s = idleStim();
        repeat (3) applyStimulus(s);
        s.valid = 1; s.halt = 1; applyStimulus(s);
        s = idleStim();
        repeat (3) applyStimulus(s);
        checkOutput("t5_halted", 32'(hfu.halted),    1);
        checkOutput("t5_cnt",    32'(hfu.stall_cnt), 4);
        s.rst = 1; applyStimulus(s);
        checkOutput("t5_rst_halted", 32'(hfu.halted),    0);
        checkOutput("t5_rst_cnt",    32'(hfu.stall_cnt), 0);

        // Randomized traffic. Occasional resets release halts and exercise counter saturation.
        for (int i = 0; i < 2000; i++) begin
            s.rs1      = AW'($urandom);
            s.rs2      = AW'($urandom);
            s.use1     = 1'($urandom);
            s.use2     = 1'($urandom);
            s.valid    = ($urandom_range(0, 7) != 0);
            s.halt     = ($urandom_range(0, 39) == 0);
            s.exRd     = AW'($urandom);
            s.exWe     = 1'($urandom);
            s.exMr     = 1'($urandom);
            s.memRd    = AW'($urandom);
            s.memWe    = 1'($urandom);
            s.wbRd     = AW'($urandom);
            s.wbWe     = 1'($urandom);
            s.redirect = ($urandom_range(0, 15) == 0);
            s.rst      = ($urandom_range(0, 149) == 0);
            applyStimulus(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
